// File: rtl/dsocm_bram_dp_ctrl.sv
// Dual-port BRAM controller for the data-side OCM path: byte-lane writes, defined
// same-word collision merge (port A wins per lane), read-valid strobes, collision counter.

module dsocm_bram_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          acc,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] dout,
  output logic          vld
);
  logic [LAT:1]         vld_pipe;
  logic [LAT:1][DW-1:0] data_pipe;

  // Data stages only load on a valid beat so the output holds between reads.
  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      if (acc) data_pipe[1] <= rdata;
      for (int k = 2; k <= LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
      end
    end
  end

  assign dout = data_pipe[LAT];
  assign vld  = vld_pipe[LAT];
endmodule

module dsocm_bram_dp_ctrl #(
  parameter int    C_MEMSIZE      = 'h4000,
  parameter int    C_PORT_DWIDTH  = 32,
  parameter int    C_PORT_AWIDTH  = 32,
  parameter int    C_NUM_WE       = 4,
  parameter int    C_READ_LATENCY = 1,
  parameter int    C_WRITE_MODE   = 0,
  parameter int    C_CNT_WIDTH    = 16,
  parameter string C_FAMILY       = "virtex2p"
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_N,
  input  logic                     BRAM_EN_A,
  input  logic [0:C_NUM_WE-1]      BRAM_WEN_A,
  input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Din_A,
  output logic                     BRAM_RdValid_A,
  input  logic                     BRAM_EN_B,
  input  logic [0:C_NUM_WE-1]      BRAM_WEN_B,
  input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Din_B,
  output logic                     BRAM_RdValid_B,
  input  logic                     Cnt_Clr,
  output logic                     Collision,
  output logic [0:C_CNT_WIDTH-1]   Collision_Cnt
);
  localparam int DW    = C_PORT_DWIDTH;
  localparam int AW    = C_PORT_AWIDTH;
  localparam int NW    = C_NUM_WE;
  localparam int DEPTH = C_MEMSIZE / C_NUM_WE;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] NW_A    = AW'(NW);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  if (NW * 8 != DW) begin : g_bad_we
    $error("C_NUM_WE must equal C_PORT_DWIDTH/8");
  end
  if (DW != 32 && DW != 64) begin : g_bad_dw
    $error("C_PORT_DWIDTH must be 32 or 64");
  end
  if (C_READ_LATENCY != 1 && C_READ_LATENCY != 2) begin : g_bad_lat
    $error("C_READ_LATENCY must be 1 or 2");
  end
  if (C_MEMSIZE <= 0 || (C_MEMSIZE & (C_MEMSIZE - 1)) != 0 || C_MEMSIZE < 2 * NW) begin : g_bad_size
    $error("C_MEMSIZE must be a power of two of at least two words");
  end
  if (C_WRITE_MODE != 0 && C_WRITE_MODE != 1) begin : g_bad_mode
    $error("C_WRITE_MODE must be 0 or 1");
  end
  if (C_FAMILY == "") begin : g_bad_family
    $error("C_FAMILY must name a target family");
  end

  logic [DW-1:0]    mem [DEPTH];
  logic             en_a, en_b, coll, wr_coll, write_a, write_b;
  logic [0:NW-1]    wen_a, wen_b;
  logic [AW-1:0]    addr_a, addr_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic [DW-1:0]    wd_a, wd_b, old_a, old_b, new_a, new_b;
  logic [1:0]           acc, vld;
  logic [1:0][DW-1:0]   rdata, dout;
  logic                 coll_q;
  logic [C_CNT_WIDTH-1:0] cnt;

  // Accesses are suppressed while reset is held so memory is left untouched.
  assign en_a   = BRAM_Rst_N & BRAM_EN_A;
  assign en_b   = BRAM_Rst_N & BRAM_EN_B;
  assign wen_a  = en_a ? BRAM_WEN_A : '0;
  assign wen_b  = en_b ? BRAM_WEN_B : '0;
  assign addr_a = BRAM_Addr_A;
  assign addr_b = BRAM_Addr_B;
  assign wd_a   = BRAM_Dout_A;
  assign wd_b   = BRAM_Dout_B;
  assign idx_a  = IDX_W'((addr_a / NW_A) % DEPTH_A);
  assign idx_b  = IDX_W'((addr_b / NW_A) % DEPTH_A);
  assign old_a  = mem[idx_a];
  assign old_b  = mem[idx_b];

  assign coll    = en_a & en_b & (idx_a == idx_b);
  assign wr_coll = coll & ((|wen_a) | (|wen_b));

  // Post-write words; on a collision both ports see the same A-priority merge.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NW; i++) begin
      if (wen_a[i])              new_a[DW-1-8*i -: 8] = wd_a[DW-1-8*i -: 8];
      else if (coll && wen_b[i]) new_a[DW-1-8*i -: 8] = wd_b[DW-1-8*i -: 8];
      if (coll && wen_a[i])      new_b[DW-1-8*i -: 8] = wd_a[DW-1-8*i -: 8];
      else if (wen_b[i])         new_b[DW-1-8*i -: 8] = wd_b[DW-1-8*i -: 8];
    end
  end

  // On a collision only port A commits the merged word, so the two writes never race.
  assign write_a = (|wen_a) | (coll & (|wen_b));
  assign write_b = (|wen_b) & ~coll;

  always_ff @(posedge BRAM_Clk) begin
    if (write_a) mem[idx_a] <= new_a;
    if (write_b) mem[idx_b] <= new_b;
  end

  assign acc      = {en_b, en_a};
  assign rdata[0] = (C_WRITE_MODE == 1) ? new_a : old_a;
  assign rdata[1] = (C_WRITE_MODE == 1) ? new_b : old_b;

  dsocm_bram_rd_pipe #(.DW(DW), .LAT(C_READ_LATENCY)) u_rd_pipe [1:0] (
    .gclk   (BRAM_Clk),
    .grst_n (BRAM_Rst_N),
    .acc    (acc),
    .rdata  (rdata),
    .dout   (dout),
    .vld    (vld)
  );

  assign BRAM_Din_A     = dout[0];
  assign BRAM_Din_B     = dout[1];
  assign BRAM_RdValid_A = vld[0];
  assign BRAM_RdValid_B = vld[1];

  always_ff @(posedge BRAM_Clk) begin
    if (!BRAM_Rst_N) begin
      coll_q <= 1'b0;
      cnt    <= '0;
    end else begin
      coll_q <= wr_coll;
      if (Cnt_Clr)                cnt <= '0;
      else if (wr_coll && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end

  assign Collision     = coll_q;
  assign Collision_Cnt = cnt;
endmodule

// File: tb/tb_dsocm_bram_dp_ctrl.sv
// Bench for dsocm_bram_dp_ctrl: a read-first/latency-1 and a write-first/latency-2
// instance share stimulus; table rows carry hand-computed results for both.

module tb_dsocm_bram_dp_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b, clr;
  logic [0:3]  wen_a, wen_b;
  logic [0:31] addr_a, addr_b, dat_a, dat_b;
  logic [0:31] din_a0, din_b0, din_a1, din_b1;
  logic        vld_a0, vld_b0, vld_a1, vld_b1, coll0, coll1;
  logic [0:1]  cnt0, cnt1;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dsocm_bram_dp_ctrl #(.C_READ_LATENCY(1), .C_WRITE_MODE(0), .C_CNT_WIDTH(2)) u0 (
    .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
    .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(dat_a),
    .BRAM_Din_A(din_a0), .BRAM_RdValid_A(vld_a0),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(dat_b),
    .BRAM_Din_B(din_b0), .BRAM_RdValid_B(vld_b0),
    .Cnt_Clr(clr), .Collision(coll0), .Collision_Cnt(cnt0));

  dsocm_bram_dp_ctrl #(.C_READ_LATENCY(2), .C_WRITE_MODE(1), .C_CNT_WIDTH(2)) u1 (
    .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
    .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(dat_a),
    .BRAM_Din_A(din_a1), .BRAM_RdValid_A(vld_a1),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(dat_b),
    .BRAM_Din_B(din_b1), .BRAM_RdValid_B(vld_b1),
    .Cnt_Clr(clr), .Collision(coll1), .Collision_Cnt(cnt1));

  typedef struct {
    logic        en_a;
    logic [3:0]  wen_a;
    logic [31:0] addr_a, dat_a;
    logic        en_b;
    logic [3:0]  wen_b;
    logic [31:0] addr_b, dat_b;
    logic        clr;
    logic [31:0] rf_a, wf_a, rf_b, wf_b;
    logic        coll;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic ea, input logic [3:0] wa, input logic [31:0] aa, da,
                              input logic eb, input logic [3:0] wb, input logic [31:0] ab, db,
                              input logic cl, input logic [31:0] rfa, wfa, rfb, wfb,
                              input logic co, input logic [1:0] cn);
    vec_t v;
    v.en_a = ea; v.wen_a = wa; v.addr_a = aa; v.dat_a = da;
    v.en_b = eb; v.wen_b = wb; v.addr_b = ab; v.dat_b = db;
    v.clr = cl; v.rf_a = rfa; v.wf_a = wfa; v.rf_b = rfb; v.wf_b = wfb;
    v.coll = co; v.cnt = cn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ea, input logic [3:0] wa, input logic [31:0] aa, da,
                       input logic eb, input logic [3:0] wb, input logic [31:0] ab, db,
                       input logic cl);
    en_a = ea; wen_a = wa; addr_a = aa; dat_a = da;
    en_b = eb; wen_b = wb; addr_b = ab; dat_b = db;
    clr = cl;
  endtask

  initial begin
    logic [31:0] h0a, h0b, h1a, h1b;
    vec_t p;

    tbl[0]  = mk(1, 4'b1111, 'h10, 'h11223344, 1, 4'b0000, 'h20, 0, 0, 0, 'h11223344, 0, 0, 0, 0);
    tbl[1]  = mk(1, 4'b0000, 'h10, 0, 1, 4'b0000, 'h30, 0, 0, 'h11223344, 'h11223344, 0, 0, 0, 0);
    tbl[2]  = mk(1, 4'b0100, 'h10, 'hAABBCCDD, 0, 4'b0000, 0, 0, 0, 'h11223344, 'h11BB3344, 0, 0, 0, 0);
    tbl[3]  = mk(0, 4'b0000, 0, 0, 1, 4'b0000, 'h10, 0, 0, 0, 0, 'h11BB3344, 'h11BB3344, 0, 0);
    tbl[4]  = mk(1, 4'b1100, 'h20, 'hAAAAAAAA, 1, 4'b0110, 'h20, 'hBBBBBBBB, 0,
                 0, 'hAAAABB00, 0, 'hAAAABB00, 1, 1);
    tbl[5]  = mk(1, 4'b0000, 'h20, 0, 1, 4'b0000, 'h20, 0, 0,
                 'hAAAABB00, 'hAAAABB00, 'hAAAABB00, 'hAAAABB00, 0, 1);
    tbl[6]  = mk(1, 4'b0000, 'h4010, 0, 1, 4'b1111, 'h4030, 'hCAFEF00D, 0,
                 'h11BB3344, 'h11BB3344, 0, 'hCAFEF00D, 0, 1);
    tbl[7]  = mk(1, 4'b0000, 'h30, 0, 1, 4'b0001, 'h30, 'h12345678, 0,
                 'hCAFEF00D, 'hCAFEF078, 'hCAFEF00D, 'hCAFEF078, 1, 2);
    tbl[8]  = mk(1, 4'b1010, 'h40, 'h01020304, 1, 4'b1111, 'h8040, 'h05060708, 0,
                 0, 'h01060308, 0, 'h01060308, 1, 3);
    tbl[9]  = mk(1, 4'b0001, 'h10, 'h000000EE, 1, 4'b0000, 'h10, 0, 0,
                 'h11BB3344, 'h11BB33EE, 'h11BB3344, 'h11BB33EE, 1, 3);
    tbl[10] = mk(1, 4'b0000, 'h10, 0, 1, 4'b1000, 'h10, 'h99000000, 0,
                 'h11BB33EE, 'h99BB33EE, 'h11BB33EE, 'h99BB33EE, 1, 3);
    tbl[11] = mk(1, 4'b0001, 'h20, 'h00000055, 1, 4'b0001, 'h20, 'h00000066, 1,
                 'hAAAABB00, 'hAAAABB55, 'hAAAABB00, 'hAAAABB55, 1, 0);
    tbl[12] = mk(0, 4'b1111, 'h10, 'hFFFFFFFF, 0, 4'b1111, 'h10, 'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 4'b0000, 'h10, 0, 1, 4'b0000, 'h20, 0, 0,
                 'h99BB33EE, 'h99BB33EE, 'hAAAABB55, 'hAAAABB55, 0, 0);
    tbl[14] = mk(1, 4'b0000, 'h40, 0, 1, 4'b0000, 'h30, 0, 0,
                 'h01060308, 'h01060308, 'hCAFEF078, 'hCAFEF078, 0, 0);
    tbl[15] = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    rst_n = 1'b0;
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    step(); step();
    chk("rst din_a0", din_a0, 0);   chk("rst din_b0", din_b0, 0);
    chk("rst din_a1", din_a1, 0);   chk("rst din_b1", din_b1, 0);
    chk("rst vld", 32'({vld_a0, vld_b0, vld_a1, vld_b1}), 0);
    chk("rst coll", 32'({coll0, coll1}), 0);
    chk("rst cnt0", 32'(cnt0), 0);  chk("rst cnt1", 32'(cnt1), 0);

    // Zero the words the table uses so read-first results are known.
    rst_n = 1'b1;
    drive(1, 4'b1111, 'h10, 0, 1, 4'b1111, 'h20, 0, 0); step();
    drive(1, 4'b1111, 'h30, 0, 1, 4'b1111, 'h40, 0, 0); step();
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);       step(); step();

    h0a = 0; h0b = 0; h1a = 0; h1b = 0;
    p = tbl[15];
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en_a, tbl[i].wen_a, tbl[i].addr_a, tbl[i].dat_a,
            tbl[i].en_b, tbl[i].wen_b, tbl[i].addr_b, tbl[i].dat_b, tbl[i].clr);
      step();
      if (tbl[i].en_a) h0a = tbl[i].rf_a;
      if (tbl[i].en_b) h0b = tbl[i].rf_b;
      chk($sformatf("r%0d u0 vld_a", i), 32'(vld_a0), 32'(tbl[i].en_a));
      chk($sformatf("r%0d u0 din_a", i), din_a0, h0a);
      chk($sformatf("r%0d u0 vld_b", i), 32'(vld_b0), 32'(tbl[i].en_b));
      chk($sformatf("r%0d u0 din_b", i), din_b0, h0b);
      chk($sformatf("r%0d u0 coll", i), 32'(coll0), 32'(tbl[i].coll));
      chk($sformatf("r%0d u0 cnt", i), 32'(cnt0), 32'(tbl[i].cnt));
      chk($sformatf("r%0d u1 coll", i), 32'(coll1), 32'(tbl[i].coll));
      chk($sformatf("r%0d u1 cnt", i), 32'(cnt1), 32'(tbl[i].cnt));
      // Latency-2 instance shows the previous row's access now.
      if (p.en_a) h1a = p.wf_a;
      if (p.en_b) h1b = p.wf_b;
      chk($sformatf("r%0d u1 vld_a", i), 32'(vld_a1), 32'(p.en_a));
      chk($sformatf("r%0d u1 din_a", i), din_a1, h1a);
      chk($sformatf("r%0d u1 vld_b", i), 32'(vld_b1), 32'(p.en_b));
      chk($sformatf("r%0d u1 din_b", i), din_b1, h1b);
      p = tbl[i];
    end

    // Reset while reads are in flight; a write attempted under reset must not land.
    drive(1, 4'b0000, 'h10, 0, 1, 4'b1000, 'h10, 'h99000000, 0);
    step();
    chk("mid u0 vld_a", 32'(vld_a0), 1);
    chk("mid u0 din_a", din_a0, 'h99BB33EE);
    chk("mid u0 coll", 32'(coll0), 1);
    chk("mid u1 cnt", 32'(cnt1), 1);
    rst_n = 1'b0;
    drive(1, 4'b1111, 'h10, 'hFFFFFFFF, 1, 4'b1111, 'h10, 'hFFFFFFFF, 0);
    step();
    chk("rst2 u0 vld_a", 32'(vld_a0), 0);
    chk("rst2 u0 din_a", din_a0, 0);
    chk("rst2 u1 vld_a", 32'(vld_a1), 0);
    chk("rst2 u1 din_a", din_a1, 0);
    chk("rst2 coll", 32'({coll0, coll1}), 0);
    chk("rst2 cnt0", 32'(cnt0), 0);
    chk("rst2 cnt1", 32'(cnt1), 0);
    rst_n = 1'b1;
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    step();
    chk("post u1 vld_a", 32'(vld_a1), 0);
    chk("post u1 din_a", din_a1, 0);
    chk("post coll", 32'({coll0, coll1}), 0);
    drive(1, 4'b0000, 'h10, 0, 0, 4'b0000, 0, 0, 0);
    step();
    chk("keep u0 vld_a", 32'(vld_a0), 1);
    chk("keep u0 din_a", din_a0, 'h99BB33EE);
    drive(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    step();
    chk("keep u1 vld_a", 32'(vld_a1), 1);
    chk("keep u1 din_a", din_a1, 'h99BB33EE);
    chk("hold u0 vld_a", 32'(vld_a0), 0);
    chk("hold u0 din_a", din_a0, 'h99BB33EE);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
